// File: rtl/des_key_sched_seq.sv
// des_key_sched_seq: sequential DES/3DES key scheduler streaming one 48-bit subkey per handshake.
module des_key_sched_seq #(
   parameter int NUM_KEYS = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [64*NUM_KEYS-1:0]  i_key,
   input  logic                    i_decrypt,
   input  logic                    i_valid,
   output logic                    o_ready,
   output logic                    o_sk_valid,
   input  logic                    i_sk_ready,
   output logic [47:0]             o_subkey,
   output logic [3:0]              o_round,
   output logic [1:0]              o_pass,
   output logic                    o_last
);
   if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_num_keys
      $error("des_key_sched_seq: NUM_KEYS must be 1 or 3");
   end
   localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                               10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                               63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                               14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                               23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                               41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                               44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   typedef enum logic {IDLE, RUN} state_t;
   state_t                 r_state;
   logic [64*NUM_KEYS-1:0] r_key;
   logic                   r_dec;
   logic                   r_dir;
   logic [55:0]            r_cd;
   logic [3:0]             r_round;
   logic [1:0]             r_pass;
   logic [63:0]            w_keys [3];
   logic [63:0]            w_ld_key;
   logic [3:0]             w_nr;
   logic                   w_two;
   logic [1:0]             w_np;
   logic [1:0]             w_np_idx;
   logic                   w_np_dir;
   logic                   w_last_pass;

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] v;
      for (int i = 0; i < 56; i++) v[6'(55 - i)] = k[6'(64 - PC1[i])];
      return v;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] v;
      for (int i = 0; i < 48; i++) v[6'(47 - i)] = cd[6'(56 - PC2[i])];
      return v;
   endfunction

   function automatic logic [27:0] rot(input logic [27:0] h, input logic left, input logic two);
      return left ? (two ? {h[25:0], h[27:26]} : {h[26:0], h[27]})
                  : (two ? {h[1:0], h[27:2]} : {h[0], h[27:1]});
   endfunction

   function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic left, input logic two);
      return {rot(cd[55:28], left, two), rot(cd[27:0], left, two)};
   endfunction

   // encrypt passes enter round 1 already rotated; decrypt passes start at K16 = PC1 itself
   function automatic logic [55:0] pass_start(input logic [63:0] k, input logic dir);
      return dir ? pc1(k) : rot_cd(pc1(k), 1'b1, 1'b0);
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_keys
      assign w_keys[k] = r_key[64*(k % NUM_KEYS) +: 64];
   end

   assign w_ld_key    = i_decrypt ? i_key[64*NUM_KEYS-1 -: 64] : i_key[63:0];
   assign w_nr        = r_round + 4'd1;
   assign w_two       = !(w_nr == 4'd1 || w_nr == 4'd8 || w_nr == 4'd15);
   assign w_np        = r_pass + 2'd1;
   assign w_np_idx    = r_dec ? 2'(NUM_KEYS - 2 - int'(r_pass)) : w_np;
   assign w_np_dir    = r_dec ^ (w_np == 2'd1);
   assign w_last_pass = r_pass == 2'(NUM_KEYS - 1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_key   <= '0;
         r_dec   <= 1'b0;
         r_dir   <= 1'b0;
         r_cd    <= '0;
         r_round <= '0;
         r_pass  <= '0;
      end else if (r_state == IDLE) begin
         if (i_valid) begin
            r_state <= RUN;
            r_key   <= i_key;
            r_dec   <= i_decrypt;
            r_dir   <= i_decrypt;
            r_cd    <= pass_start(w_ld_key, i_decrypt);
            r_round <= '0;
            r_pass  <= '0;
         end
      end else if (i_sk_ready) begin
         if (r_round != 4'd15) begin
            r_round <= w_nr;
            r_cd    <= rot_cd(r_cd, !r_dir, w_two);
         end else if (!w_last_pass) begin
            r_pass  <= w_np;
            r_round <= '0;
            r_dir   <= w_np_dir;
            r_cd    <= pass_start(w_keys[w_np_idx], w_np_dir);
         end else begin
            r_state <= IDLE;
            r_round <= '0;
            r_pass  <= '0;
         end
      end
   end

   assign o_ready    = r_state == IDLE;
   assign o_sk_valid = r_state == RUN;
   assign o_subkey   = pc2(r_cd);
   assign o_round    = r_round;
   assign o_pass     = r_pass;
   assign o_last     = o_sk_valid && r_round == 4'd15 && w_last_pass;
endmodule

// File: tb/tb_des_key_sched_seq.sv
// tb_des_key_sched_seq: directed checks of the DES/3DES key scheduler against a textbook key-schedule model.
module tb_des_key_sched_seq;
   localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                               10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                               63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                               14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                               23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                               41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                               44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam logic [63:0] KT = 64'h133457799BBCDFF1;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         vld = 1'b0;
   logic         dec = 1'b0;
   logic         skr = 1'b1;
   logic         use3 = 1'b0;
   logic [191:0] key = '0;
   logic         rdy1, skv1, lst1, rdy3, skv3, lst3;
   logic [47:0]  sk1, sk3;
   logic [3:0]   rnd1, rnd3;
   logic [1:0]   pas1, pas3;
   logic [47:0]  got [48];
   logic [191:0] kr;
   int           errs = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   des_key_sched_seq #(.NUM_KEYS(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_key(key[63:0]), .i_decrypt(dec), .i_valid(vld && !use3),
      .o_ready(rdy1), .o_sk_valid(skv1), .i_sk_ready(skr), .o_subkey(sk1), .o_round(rnd1),
      .o_pass(pas1), .o_last(lst1));

   des_key_sched_seq #(.NUM_KEYS(3)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_key(key), .i_decrypt(dec), .i_valid(vld && use3),
      .o_ready(rdy3), .o_sk_valid(skv3), .i_sk_ready(skr), .o_subkey(sk3), .o_round(rnd3),
      .o_pass(pas3), .o_last(lst3));

   wire        w_rdy = use3 ? rdy3 : rdy1;
   wire        w_skv = use3 ? skv3 : skv1;
   wire [47:0] w_sk  = use3 ? sk3 : sk1;
   wire [55:0] w_obs = use3 ? {skv3, sk3, rnd3, pas3, lst3} : {skv1, sk1, rnd1, pas1, lst1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // textbook schedule: subkey r (1..16) from PC1 plus cumulative left shifts
   function automatic logic [47:0] ref_sk(input logic [63:0] k, input int r);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] sk;
      for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int j = 1; j <= r; j++)
         for (int s = 0; s < ((j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2); s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[47-i] = cd[56-PC2[i]];
      return sk;
   endfunction

   function automatic logic [47:0] exp_sk(input int nk, input logic [191:0] k, input logic d, input int idx);
      int p, n, ki;
      logic dir;
      p = idx / 16;
      n = idx % 16;
      ki = (nk == 1) ? 0 : (d ? 2 - p : p);
      dir = (nk == 1) ? d : (d ? (p != 1) : (p == 1));
      return dir ? ref_sk(k[64*ki +: 64], 16 - n) : ref_sk(k[64*ki +: 64], n + 1);
   endfunction

   function automatic logic [55:0] exp_obs(input int nk, input logic [191:0] k, input logic d, input int idx);
      return {1'b1, exp_sk(nk, k, d, idx), 4'(idx % 16), 2'(idx / 16), idx == 16*nk - 1};
   endfunction

   task automatic stream(input int nk, input logic [191:0] k, input logic d, input bit stall,
                         input bit hold_v, input int stop_at);
      int n, idx, cyc;
      bit hs;
      n = 16 * nk;
      idx = 0;
      cyc = 0;
      use3 = (nk == 3);
      chk("ready_before_load", 64'(w_rdy), 64'd1);
      key = k;
      dec = d;
      vld = 1'b1;
      @(posedge clk); #1;
      vld = hold_v;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      dec = ~d;
      while (idx < stop_at && cyc < 4000) begin
         hs = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         skr = hs;
         chk($sformatf("stream nk%0d dec%0d idx%0d", nk, d, idx), {7'd0, w_rdy, w_obs}, {8'd0, exp_obs(nk, k, d, idx)});
         if (hs) got[idx] = w_sk;
         @(posedge clk); #1;
         cyc++;
         if (hs) idx++;
      end
      vld = 1'b0;
      skr = 1'b1;
      chk("stream_timeout", 64'(cyc < 4000), 64'd1);
      if (stop_at == n) begin
         chk("end_idle", {62'd0, w_rdy, w_skv}, 64'b10);
         if (!stall) chk("throughput", 64'(cyc), 64'(n));
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset1", {7'd0, rdy1, skv1, sk1, rnd1, pas1, lst1}, {7'd0, 1'b1, 56'd0});
      chk("reset3", {7'd0, rdy3, skv3, sk3, rnd3, pas3, lst3}, {7'd0, 1'b1, 56'd0});
      rst = 1'b0;
      @(posedge clk); #1;
      stream(1, {128'd0, KT}, 1'b0, 1'b0, 1'b0, 16);
      chk("enc_k1", 64'(got[0]), 64'h1B02EFFC7072);
      chk("enc_k2", 64'(got[1]), 64'h79AED9DBC9E5);
      chk("enc_k16", 64'(got[15]), 64'hCB3D8B0E17F5);
      stream(1, {128'd0, KT}, 1'b1, 1'b0, 1'b0, 16);
      chk("dec_first", 64'(got[0]), 64'hCB3D8B0E17F5);
      chk("dec_second", 64'(got[1]), 64'(ref_sk(KT, 15)));
      chk("dec_last", 64'(got[15]), 64'h1B02EFFC7072);
      kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      stream(1, kr, 1'b0, 1'b1, 1'b0, 16);
      stream(1, kr, 1'b1, 1'b1, 1'b0, 16);
      stream(3, {3{KT}}, 1'b0, 1'b0, 1'b0, 48);
      chk("ede_p1_first", 64'(got[16]), 64'hCB3D8B0E17F5);
      chk("ede_p2_first", 64'(got[32]), 64'h1B02EFFC7072);
      kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      stream(3, kr, 1'b1, 1'b0, 1'b0, 48);
      stream(3, kr, 1'b0, 1'b1, 1'b1, 48);
      stream(3, kr, 1'b0, 1'b0, 1'b0, 23);
      chk("pre_reset_pos", {8'd0, w_obs}, {8'd0, exp_obs(3, kr, 1'b0, 23)});
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_run_reset", {7'd0, rdy3, skv3, sk3, rnd3, pas3, lst3}, {7'd0, 1'b1, 56'd0});
      vld = 1'b1;
      @(posedge clk); #1;
      chk("rst_beats_valid", {62'd0, rdy3, skv3}, 64'b10);
      rst = 1'b0;
      vld = 1'b0;
      @(posedge clk); #1;
      stream(3, kr, 1'b1, 1'b0, 1'b0, 48);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
